// File: rtl/preproc_input_conditioner.sv
// preproc_input_conditioner
// ADC input conditioning ahead of the preprocessing stage: source select,
// offset removal with saturation, and an output FIFO with ready/valid.
// Small register file: OFFSET, SEL_SOURCE, STATUS (sticky flags + level).
// Build option: define PREPROC_INCOND_RAMP_EN to include the internal ramp
// source (SEL_SOURCE=1). Without it, SEL_SOURCE=1 yields zero samples.
module preproc_input_conditioner #(
    parameter int ADC_WIDTH  = 14,
    parameter int OUT_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADC_WIDTH-1:0]    adc_data_i,
    input  logic                    adc_valid_i,
    input  logic                    reg_wr_i,
    input  logic                    reg_rd_i,
    input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
    output logic [DATA_WIDTH-1:0]   reg_rdata_o,
    output logic [OUT_WIDTH-1:0]    m_data_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    // Arithmetic is done one bit wider than the output so the offset
    // subtraction cannot wrap before saturation.
    localparam int DW = OUT_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [ADDR_WIDTH-1:0] A_OFFSET = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_SEL    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(2);

    localparam logic [ADC_WIDTH-1:0] CONST_SMP = ADC_WIDTH'(4096);
    localparam logic signed [DW-1:0] SAT_MAX   = {2'b00, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN   = {2'b11, {(OUT_WIDTH-1){1'b0}}};

    // ---------------- registers ----------------
    logic [15:0]          offset_q;
    logic [4:0]           sel_q;
    logic                 ovf_q, ovf_d;
    logic                 sat_q, sat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // ---------------- pipeline ----------------
    logic [ADC_WIDTH-1:0]   src_smp;
    logic signed [DW-1:0]   src_ext, off_ext, diff_d;
    logic signed [DW-1:0]   s1_diff_q;
    logic                   s1_vld_q;
    logic [OUT_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic                   s2_sat_q, s2_sat_d;
    logic                   s2_vld_q;

    // ---------------- fifo ----------------
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 fifo_full, fifo_pop, fifo_wr, fifo_drop;
    logic [3:0]           level;

    logic wr_off, wr_sel, stat_w1c;

    assign wr_off   = reg_wr_i && (reg_addr_i == A_OFFSET);
    assign wr_sel   = reg_wr_i && (reg_addr_i == A_SEL);
    assign stat_w1c = reg_wr_i && (reg_addr_i == A_STATUS) && reg_wstrb_i[0];

    // Upper write-data bytes have no backing register bits.
    logic unused_wbits;
    assign unused_wbits = ^{reg_wdata_i[DATA_WIDTH-1:16], reg_wstrb_i[DATA_WIDTH/8-1:2]};

    // OFFSET and SEL_SOURCE writes, byte-enable qualified
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
            sel_q    <= '0;
        end else begin
            if (wr_off && reg_wstrb_i[0]) offset_q[7:0]  <= reg_wdata_i[7:0];
            if (wr_off && reg_wstrb_i[1]) offset_q[15:8] <= reg_wdata_i[15:8];
            if (wr_sel && reg_wstrb_i[0]) sel_q          <= reg_wdata_i[4:0];
        end
    end

    // Sticky flags: a new event wins over a same-cycle write-1-to-clear
    always_comb begin
        ovf_d = ovf_q;
        sat_d = sat_q;
        if (stat_w1c && reg_wdata_i[0]) ovf_d = 1'b0;
        if (stat_w1c && reg_wdata_i[1]) sat_d = 1'b0;
        if (fifo_drop)                  ovf_d = 1'b1;
        if (fifo_wr && s2_sat_q)        sat_d = 1'b1;
    end

    // Sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            sat_q <= sat_d;
        end
    end

    assign level = 4'(count_q);

    // Read mux
    always_comb begin
        rdata_d = '0;
        case (reg_addr_i)
            A_OFFSET: rdata_d = DATA_WIDTH'(offset_q);
            A_SEL:    rdata_d = DATA_WIDTH'(sel_q);
            A_STATUS: rdata_d = DATA_WIDTH'({level, 2'b00, sat_q, ovf_q});
            default:  rdata_d = '0;
        endcase
    end

    // Read data is registered: valid the cycle after the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rdata_q <= '0;
        else if (reg_rd_i) rdata_q <= rdata_d;
    end

    assign reg_rdata_o = rdata_q;

`ifdef PREPROC_INCOND_RAMP_EN
    logic [ADC_WIDTH-1:0] ramp_q;

    // Free-running ramp, advances once per input strobe and wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ramp_q <= '0;
        else if (adc_valid_i) ramp_q <= ramp_q + ADC_WIDTH'(1);
    end
`endif

    // Source select; all sources share the adc_valid_i cadence
    always_comb begin
        src_smp = '0;
        case (sel_q)
            5'd0:    src_smp = adc_data_i;
`ifdef PREPROC_INCOND_RAMP_EN
            5'd1:    src_smp = ramp_q;
`endif
            5'd2:    src_smp = CONST_SMP;
            default: src_smp = '0;
        endcase
    end

    assign src_ext = {{(DW-ADC_WIDTH){src_smp[ADC_WIDTH-1]}}, src_smp};
    assign off_ext = {{(DW-16){offset_q[15]}}, offset_q};
    assign diff_d  = src_ext - off_ext;

    // Stage 1: capture the offset-corrected sample using the config
    // live at capture time, so later register writes don't touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_diff_q <= '0;
        end else begin
            s1_vld_q <= adc_valid_i;
            if (adc_valid_i) s1_diff_q <= diff_d;
        end
    end

    // Saturate the wide difference into the signed output range
    always_comb begin
        s2_sat_d  = 1'b0;
        s2_data_d = s1_diff_q[OUT_WIDTH-1:0];
        if (s1_diff_q > SAT_MAX) begin
            s2_sat_d  = 1'b1;
            s2_data_d = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s1_diff_q < SAT_MIN) begin
            s2_sat_d  = 1'b1;
            s2_data_d = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // Stage 2: saturated sample, presented to the FIFO write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_sat_q  <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_data_q <= s2_data_d;
                s2_sat_q  <= s2_sat_d;
            end
        end
    end

    // FIFO control: a full FIFO still accepts a write when it is also
    // being read in the same cycle
    assign m_valid_o = (count_q != '0);
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign fifo_pop  = m_valid_o && m_ready_i;
    assign fifo_wr   = s2_vld_q && (!fifo_full || fifo_pop);
    assign fifo_drop = s2_vld_q && fifo_full && !fifo_pop;

    // FIFO storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= s2_data_q;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({fifo_wr, fifo_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head of FIFO drives the output directly; stays put until popped
    assign m_data_o = m_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: doc/preproc_input_conditioner.md
PREPROC_INPUT_CONDITIONER -- requirements
Module: preproc_input_conditioner

Interface
REQ-001 Parameter ADC_WIDTH, default 14: width of the signed two's-complement ADC sample.
REQ-002 Parameter OUT_WIDTH, default 16: width of the signed conditioned output sample.
REQ-003 Parameter DATA_WIDTH, default 32: width of the register data bus.
REQ-004 Parameter ADDR_WIDTH, default 4: width of the register address bus.
REQ-005 Parameter FIFO_DEPTH, default 8: output FIFO entries, power of two.
REQ-006 clk  in  1  single clock (ADC domain, 260 MHz); all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 adc_data_i  in  ADC_WIDTH  raw ADC sample.
REQ-009 adc_valid_i  in  1  qualifies adc_data_i, one cycle per sample (nominally 1 in 3 cycles).
REQ-010 reg_wr_i  in  1  register write strobe.
REQ-011 reg_rd_i  in  1  register read strobe.
REQ-012 reg_addr_i  in  ADDR_WIDTH  word address.
REQ-013 reg_wdata_i  in  DATA_WIDTH  write data.
REQ-014 reg_wstrb_i  in  DATA_WIDTH/8  byte enables for writes.
REQ-015 reg_rdata_o  out  DATA_WIDTH  read data, valid one cycle after reg_rd_i.
REQ-016 m_data_o  out  OUT_WIDTH  conditioned sample to the preprocessing stage.
REQ-017 m_valid_o  out  1  m_data_o valid.
REQ-018 m_ready_i  in  1  downstream accepts; transfer when m_valid_o and m_ready_i both high.

Function
REQ-019 Registers: 0x0 OFFSET (bits 15:0, signed, R/W); 0x1 SEL_SOURCE (bits 4:0, R/W); 0x2 STATUS (bit0 overflow sticky, bit1 saturation sticky, bits 7:4 FIFO level; write-1-to-clear bits 1:0); other addresses read 0, writes ignored.
REQ-020 Writes honour reg_wstrb_i per byte; a write takes effect the cycle after reg_wr_i.
REQ-021 SEL_SOURCE: 0 = ADC input; 1 = internal ramp; 2 = constant 0x1000; 3..31 = zero samples; sources 1-3 produce samples at adc_valid_i timing.
REQ-022 Datapath: sign-extend selected sample to OUT_WIDTH+1, subtract sign-extended OFFSET, saturate to OUT_WIDTH signed range [-32768, 32767].
REQ-023 Saturation sets STATUS bit1 in the cycle the saturated sample enters the FIFO.
REQ-024 Datapath latency: 2 cycles from adc_valid_i to FIFO write; m_valid_o rises no earlier than the cycle after the FIFO write when empty (3 cycles total).
REQ-025 FIFO: FIFO_DEPTH entries, first-in first-out, pointers wrap modulo FIFO_DEPTH; m_valid_o high whenever non-empty.
REQ-026 FIFO full and sample arriving without simultaneous read: sample dropped, STATUS bit0 set, stored data unchanged.
REQ-027 FIFO full with simultaneous read and write: both occur, no drop, level unchanged.
REQ-028 m_data_o held stable while m_valid_o high and m_ready_i low.
REQ-029 SEL_SOURCE or OFFSET change applies to samples entering stage 1 on the following cycle; samples already in flight are unaffected.
REQ-030 Simultaneous W1C and new sticky event in the same cycle: bit ends set.

Reset
REQ-031 On rst_n low (asynchronous): OFFSET=0, SEL_SOURCE=0, STATUS=0, FIFO empty, pipeline valids 0, ramp counter 0, m_valid_o=0, m_data_o=0, reg_rdata_o=0.
REQ-032 Reset mid-operation discards all in-flight and buffered samples; first post-reset output is from a sample arriving after rst_n deasserts.

Configuration
REQ-033 Macro PREPROC_INCOND_RAMP_EN: when defined, SEL_SOURCE=1 outputs a ramp that increments by 1 per adc_valid_i, wrapping +8191 to -8192 (ADC_WIDTH signed).
REQ-034 When PREPROC_INCOND_RAMP_EN is undefined, ramp logic is absent and SEL_SOURCE=1 behaves as zero samples.

Verification
REQ-035 Reset, SEL=0, OFFSET=0, adc_data_i=0x0123 valid, m_ready_i=1 -> m_data_o=0x0123, m_valid_o rises 3 cycles after input.
REQ-036 OFFSET=0x0100, adc_data_i=-8192 (0x2000) -> m_data_o=-8448 (0xDF00), no saturation flag.
REQ-037 OFFSET=0x8000 (-32768), adc_data_i=0x1FFF -> m_data_o=0x7FFF, STATUS bit1=1; write 0x2 with 0x2 -> bit1=0.
REQ-038 m_ready_i=0, 10 samples 1..10 -> FIFO holds 1..8, STATUS bit0=1, level=8; release m_ready_i -> outputs 1..8 in order.
REQ-039 With ramp enabled, SEL=1, 16400 valid strobes -> outputs 0,1,...,8191,-8192,... continuous; with macro undefined -> all zeros.
REQ-040 rst_n pulsed low with 5 samples buffered -> m_valid_o=0 immediately, STATUS=0, OFFSET=0 on readback.
